// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game round controller.
package simon_pkg;

  localparam int ENTRY_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    WAIT_INPUT,
    PAUSE,
    GAME_OVER,
    VICTORY
  } state_t;

  localparam logic [ENTRY_W-1:0] RED    = 4'b0001;
  localparam logic [ENTRY_W-1:0] GREEN  = 4'b0010;
  localparam logic [ENTRY_W-1:0] BLUE   = 4'b0100;
  localparam logic [ENTRY_W-1:0] YELLOW = 4'b1000;

  // Two random bits pick one of the four colours.
  function automatic logic [ENTRY_W-1:0] colour_of(input logic [1:0] sel);
    return RED << sel;
  endfunction

endpackage

// File: rtl/simon_round_controller_if.sv
// Signals between the round controller, the keys/LED pins and the sequence detector.
interface simon_round_controller_if
  import simon_pkg::*;
#(
  parameter int MAX_LEN = 10
);

  logic                       start;
  logic                       det_correct;
  logic                       det_game_over;
  logic [ENTRY_W*MAX_LEN-1:0] seq;
  logic [3:0]                 seq_size;
  logic                       start_reading;
  logic [ENTRY_W-1:0]         led;
  logic [3:0]                 level;
  logic                       busy;
  logic                       game_over;
  logic                       win;

  // The controller is the master; the pins and detector sit on the slave side.
  modport master (
    input  start, det_correct, det_game_over,
    output seq, seq_size, start_reading, led, level, busy, game_over, win
  );

  modport slave (
    output start, det_correct, det_game_over,
    input  seq, seq_size, start_reading, led, level, busy, game_over, win
  );

endinterface

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying colour bits.
module simon_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  output logic [1:0] rnd
);

  logic [15:0] state;

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= SEED;
    end else if (enable) begin
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end
  end

  assign rnd = state[1:0];

endmodule

// File: rtl/simon_round_controller.sv
// Simon round sequencer: grows the colour sequence, plays it back, then arms the detector.
module simon_round_controller
  import simon_pkg::*;
#(
  parameter int          ON_CYCLES  = 25_000_000,
  parameter int          OFF_CYCLES = 12_500_000,
  parameter int          MAX_LEN    = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic                      CLOCK_50,
  input logic                      reset,
  simon_round_controller_if.master bus
);

  localparam int T_MAX = (ON_CYCLES > 2 * OFF_CYCLES) ? ON_CYCLES : 2 * OFF_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] PAUSE_LAST = TW'(2 * OFF_CYCLES - 1);
  localparam logic [3:0]    MAX_SIZE   = 4'(MAX_LEN);

  state_t                          state, state_next;
  logic [TW-1:0]                   timer;
  logic [MAX_LEN-1:0][ENTRY_W-1:0] seq_q;
  logic [3:0]                      seq_size_q;
  logic [3:0]                      level_q;
  logic [3:0]                      idx;
  logic [1:0]                      rnd;
  logic                            timed;

  logic [ENTRY_W-1:0] led;
  logic               start_reading, busy, game_over, win;

  simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (1'b1),
    .rnd      (rnd)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first in every always_comb so no path leaves a value unassigned and infers a latch.
    state_next = state;
    case (state)
      IDLE, GAME_OVER, VICTORY: if (bus.start) state_next = GEN;
      GEN:      state_next = SHOW_ON;
      SHOW_ON:  if (timer == ON_LAST) state_next = SHOW_OFF;
      SHOW_OFF: if (timer == OFF_LAST)
                  state_next = (idx == seq_size_q - 4'd1) ? WAIT_INPUT : SHOW_ON;
      WAIT_INPUT: begin
        if (bus.det_game_over)    state_next = GAME_OVER;
        else if (bus.det_correct) state_next = (seq_size_q == MAX_SIZE) ? VICTORY : PAUSE;
      end
      PAUSE:    if (timer == PAUSE_LAST) state_next = GEN;
      default:  state_next = IDLE;
    endcase
  end

  assign timed = (state == SHOW_ON) || (state == SHOW_OFF) || (state == PAUSE);

  always_ff @(posedge CLOCK_50) begin
    // NOTE: the sequence register is reset as well because it drives the seq output directly.
    if (reset) begin
      timer      <= '0;
      seq_q      <= '0;
      seq_size_q <= '0;
      level_q    <= '0;
      idx        <= '0;
    end else begin
      timer <= (!timed || state_next != state) ? '0 : timer + TW'(1);
      case (state)
        IDLE, GAME_OVER, VICTORY: begin
          if (bus.start) begin
            seq_q      <= '0;
            seq_size_q <= '0;
            level_q    <= '0;
          end
        end
        GEN: begin
          seq_q[seq_size_q] <= colour_of(rnd);
          seq_size_q        <= seq_size_q + 4'd1;
          idx               <= '0;
        end
        SHOW_OFF: if (state_next == SHOW_ON) idx <= idx + 4'd1;
        WAIT_INPUT: begin
          if (!bus.det_game_over && bus.det_correct && level_q != MAX_SIZE)
            level_q <= level_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led           = '0;
    start_reading = 1'b1;
    busy          = 1'b1;
    game_over     = 1'b0;
    win           = 1'b0;
    case (state)
      IDLE:       busy = 1'b0;
      GAME_OVER:  begin busy = 1'b0; game_over = 1'b1; end
      VICTORY:    begin busy = 1'b0; win = 1'b1; end
      SHOW_ON:    led = seq_q[idx];
      WAIT_INPUT: start_reading = 1'b0;
      default: ;
    endcase
  end

  assign bus.seq           = seq_q;
  assign bus.seq_size      = seq_size_q;
  assign bus.level         = level_q;
  assign bus.led           = led;
  assign bus.start_reading = start_reading;
  assign bus.busy          = busy;
  assign bus.game_over     = game_over;
  assign bus.win           = win;

endmodule

// File: doc/simon_round_controller.md
Name: simon_round_controller

Overview:
- Top-level round sequencer for the Simon game.
- Grows the colour sequence by one random entry per round and plays it back on the LEDs with fixed on/off timing.
- Arms the player-input sequence detector, then reacts to its correct/gameOver verdict by advancing, ending or declaring victory.
- Sits between the keys/LED pins and the existing sequence-detector datapath, and owns level, sequence and sequenceSize.

Parameters:
- ON_CYCLES, 25_000_000, clock cycles each playback LED stays lit (0.5 s at 50 MHz).
- OFF_CYCLES, 12_500_000, dark gap cycles after each lit entry; the inter-round pause is 2*OFF_CYCLES.
- MAX_LEN, 10, sequence length that wins the game; 4 bits per entry, so seq width is 4*MAX_LEN.
- LFSR_SEED, 16'hACE1, reset value of the random generator; must be non-zero.

Ports:
- CLOCK_50  in   1   sole clock, all logic on rising edge.
- reset  in   1   synchronous, active-high reset.
- start  in   1   one-cycle pulse that begins a new game.
- det_correct  in   1   detector verdict: player entered the whole sequence correctly.
- det_game_over  in   1   detector verdict: player entered a wrong colour.
- seq  out  4*MAX_LEN  one-hot entries; entry k is at bits [4k+3:4k]; unused entries are 0.
- seq_size  out  4  current sequence length, 0 when idle.
- start_reading  out  1  held high to keep the detector in its first state; low only in WAIT_INPUT.
- led  out  4  playback LED drive, one-hot or 0.
- level  out  4  completed rounds in the current game.
- busy  out  1  high in any state except IDLE, GAME_OVER and VICTORY.
- game_over  out  1  high in the GAME_OVER state.
- win  out  1  high in the VICTORY state.

Behaviour:
- Reset values: seq=0, seq_size=0, level=0, led=0, start_reading=1, busy=0, game_over=0, win=0, timer=0, LFSR=LFSR_SEED, state=IDLE. Reset overrides everything, including mid-playback and mid-input.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts every cycle, including in IDLE, so user timing adds entropy.
- New entry: 4'b0001 << lfsr[1:0].
- IDLE / GAME_OVER / VICTORY, on start=1:
  - Clear seq, seq_size and level.
  - Go to GEN next cycle.
- GEN (1 cycle):
  - Write the new entry into slot seq_size.
  - Increment seq_size.
  - Clear idx, then go to SHOW_ON.
- SHOW_ON:
  - led = entry idx.
  - Timer counts ON_CYCLES cycles, then go to SHOW_OFF.
- SHOW_OFF:
  - led = 0.
  - Timer counts OFF_CYCLES cycles.
  - If idx == seq_size-1, go to WAIT_INPUT; else increment idx and go to SHOW_ON.
- WAIT_INPUT:
  - start_reading = 0; no timeout.
  - First cycle with det_game_over=1 → GAME_OVER.
  - Else first cycle with det_correct=1: increment level; if seq_size == MAX_LEN → VICTORY, else → PAUSE.
  - If both verdicts are high in the same cycle, game_over has priority.
  - Verdict levels held for several cycles count once, because the state changes on the first one.
- PAUSE:
  - led = 0.
  - Timer counts 2*OFF_CYCLES cycles, then go to GEN.
- Timer: width $clog2(max(ON_CYCLES, 2*OFF_CYCLES)+1). It reloads to 0 on every state entry.
- start pulses while busy=1 are ignored.
- Verdict inputs outside WAIT_INPUT are ignored.
- level saturates at MAX_LEN. It is not cleared on GAME_OVER, so the score stays visible until the next start.
- start_reading is high in every state except WAIT_INPUT.
- Playback latency: from start, LED entry 0 lights 2 cycles later (IDLE→GEN→SHOW_ON).

Decomposition:
- Shared package simon_pkg holds:
  - the state enum (IDLE, GEN, SHOW_ON, SHOW_OFF, WAIT_INPUT, PAUSE, GAME_OVER, VICTORY);
  - the colour one-hot constants RED=4'b0001, GREEN=4'b0010, BLUE=4'b0100, YELLOW=4'b1000;
  - the entry width of 4.
- One sub-module, simon_lfsr (16-bit, SEED parameter, enable tied high), produces the random bits.
- The timer and the sequence register stay inline.

Test Plan (all scenarios use ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=10):
- Reset then idle for 20 cycles → all outputs at reset values; start_reading=1; busy=0.
- start pulse → GEN on cycle +1, seq_size=1 and led lit one-hot for exactly 4 cycles from cycle +2, then led=0 for 2 cycles; start_reading falls on cycle +8 (first cycle of WAIT_INPUT).
- In WAIT_INPUT, pulse det_correct → level=1; 4-cycle pause; seq_size=2 and seq[3:0] unchanged; two entries played (4 on/2 off each).
- In round 3 WAIT_INPUT, raise det_correct and det_game_over together → GAME_OVER; game_over=1; level stays 2; busy=0; start_reading=1.
- Pass 10 rounds → after the 10th det_correct: win=1, level=10, seq_size=10, seq has no zero nibble and every nibble one-hot.
- Assert reset during SHOW_ON of round 3 → next cycle all outputs at reset values; a later start replays from seq_size=1.
- Pulse start while busy=1, and det_correct during SHOW_ON → no state, level or seq change.
